// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Time-multiplexed display scheduler for the century clock. One shared
// binary-to-BCD decoder is stepped across six time fields (sec, min, hour,
// day, month, year-of-century), and a 12-digit multiplexed 7-segment bank
// is driven one digit at a time.
//
// Each digit slot lasts SCAN_DIV cycles and walks through three states:
//   ADDR  (slot 0)             : dec_a is loaded with the field for this digit
//   LATCH (slot 1)             : digit_val is loaded from the decoder
//   SHOW  (slots 2..SCAN_DIV-1): the digit enable is driven
// ADDR and LATCH together form the inter-digit dead time, so the old and new
// digit never overlap on the pads.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              1 = scan running, 0 = display off (all outputs 0)
//   sec..year           binary time fields, 7 bits each
//   edit_sel            0 = no edit, 1..6 = field blinking (1=sec .. 6=year)
//   dec_a               value presented to the shared decoder
//   dec_unit, dec_tens  decoder result, combinational from dec_a
//   digit_val           BCD value for the active digit (11 = error glyph)
//   digit_en            one-hot digit enable, bit 2f = units of field f
//   frame_tick          high during the final cycle of each 12-digit frame
//
// Handshake: there is no valid/ready flow on this block. The decoder is a
// pure combinational function of dec_a, sampled one cycle after dec_a loads.
//
// All outputs are registered. Each one is computed from the next state, so
// digit_en is high exactly while state_q is SHOW.
module disp_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [6:0]  sec,
  input  logic [6:0]  min,
  input  logic [6:0]  hour,
  input  logic [6:0]  day,
  input  logic [6:0]  mon,
  input  logic [6:0]  year,
  input  logic [2:0]  edit_sel,
  output logic [6:0]  dec_a,
  input  logic [3:0]  dec_unit,
  input  logic [3:0]  dec_tens,
  output logic [3:0]  digit_val,
  output logic [11:0] digit_en,
  output logic        frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_LOG2 + 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [3:0]      idx_q, idx_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [5:0][6:0] snap_q, snap_d;
  logic [6:0]      dec_a_q, dec_a_d;
  logic [3:0]      digit_val_q, digit_val_d;
  logic [11:0]     digit_en_q, digit_en_d;
  logic            frame_tick_q, frame_tick_d;

  logic [5:0][6:0] live;
  logic [2:0]      fld_q, fld_d;
  logic            blank_d;

  assign live  = {year, mon, day, hour, min, sec};
  assign fld_q = idx_q[3:1];
  assign fld_d = idx_d[3:1];

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    frame_cnt_d  = frame_cnt_q;
    snap_d       = snap_q;
    dec_a_d      = dec_a_q;
    digit_val_d  = digit_val_q;
    digit_en_d   = 12'd0;
    frame_tick_d = 1'b0;
    blank_d      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = ADDR;
        slot_d  = '0;
        idx_d   = 4'd0;
      end
      ADDR: begin
        state_d = LATCH;
        slot_d  = SW'(1);
        // Digit 0 captures the whole frame's sample and feeds the decoder
        // straight from the live inputs, because the snapshot is being
        // written on this same edge.
        if (idx_q == 4'd0) begin
          snap_d  = live;
          dec_a_d = live[0];
        end else begin
          dec_a_d = snap_q[fld_q];
        end
      end
      LATCH: begin
        state_d     = SHOW;
        slot_d      = SW'(2);
        digit_val_d = idx_q[0] ? dec_tens : dec_unit;
      end
      SHOW: begin
        if (slot_q == SLOT_LAST) begin
          state_d = ADDR;
          slot_d  = '0;
          if (idx_q == 4'd11) begin
            idx_d       = 4'd0;
            frame_cnt_d = frame_cnt_q + FW'(1);
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // edit_sel 0 and 7 never match, because fld_d + 1 only spans 1..6.
    blank_d = (edit_sel == (fld_d + 3'd1)) && frame_cnt_d[BLINK_LOG2];
    if (state_d == SHOW && !blank_d) begin
      digit_en_d = 12'd1 << idx_d;
    end
    frame_tick_d = (state_d == SHOW) && (idx_d == 4'd11) && (slot_d == SLOT_LAST);

    // Display off: park everything except the snapshot. A later re-enable
    // takes a fresh snapshot at digit 0 anyway.
    if (!enable) begin
      state_d      = IDLE;
      slot_d       = '0;
      idx_d        = 4'd0;
      frame_cnt_d  = '0;
      dec_a_d      = 7'd0;
      digit_val_d  = 4'd0;
      digit_en_d   = 12'd0;
      frame_tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      idx_q        <= 4'd0;
      frame_cnt_q  <= '0;
      snap_q       <= '0;
      dec_a_q      <= 7'd0;
      digit_val_q  <= 4'd0;
      digit_en_q   <= 12'd0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      snap_q       <= snap_d;
      dec_a_q      <= dec_a_d;
      digit_val_q  <= digit_val_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign dec_a      = dec_a_q;
  assign digit_val  = digit_val_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl, using SCAN_DIV=4 and BLINK_LOG2=1.
// A behavioural binary-to-BCD decoder stands in for the shared decoder.
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [6:0]  sec, min, hour, day, mon, year;
  logic [2:0]  edit_sel;
  logic [6:0]  dec_a;
  logic [3:0]  dec_unit, dec_tens;
  logic [3:0]  digit_val;
  logic [11:0] digit_en;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(4), .BLINK_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sec(sec), .min(min), .hour(hour), .day(day), .mon(mon), .year(year),
    .edit_sel(edit_sel), .dec_a(dec_a), .dec_unit(dec_unit),
    .dec_tens(dec_tens), .digit_val(digit_val), .digit_en(digit_en),
    .frame_tick(frame_tick)
  );

  // Shared decoder: values above 99 decode to 11 in both digits.
  always_comb begin
    if (dec_a > 7'd99) begin
      dec_unit = 4'd11;
      dec_tens = 4'd11;
    end else begin
      dec_unit = 4'(dec_a % 7'd10);
      dec_tens = 4'(dec_a / 7'd10);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one frame, starting in the ADDR cycle of digit 0.
  //   digits     : expected digit_val for each idx, packed 4 bits per digit
  //   fields     : expected dec_a per field, packed 7 bits per field
  //   blank      : digit_en bits expected to be suppressed in this frame
  //   poke_slot  : digit slot in which sec is overwritten with poke_sec (-1 = none)
  //   stop_slot  : return on entry to SHOW of this slot (12 = run the whole frame)
  task automatic run_frame(input string name, input logic [47:0] digits,
                           input logic [41:0] fields, input logic [11:0] blank,
                           input int poke_slot, input logic [6:0] poke_sec,
                           input int stop_slot);
    logic [11:0] exp_en;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i == stop_slot && c == 2) return;
        if (i == poke_slot && c == 0) sec = poke_sec;
        exp_en = 12'd0;
        if (c >= 2 && !blank[i]) exp_en = 12'd1 << i;
        chk($sformatf("%s en i%0d c%0d", name, i, c), 32'(digit_en), 32'(exp_en));
        chk($sformatf("%s tick i%0d c%0d", name, i, c), 32'(frame_tick),
            32'((i == 11 && c == 3) ? 1 : 0));
        if (c == 1)
          chk($sformatf("%s dec_a i%0d", name, i), 32'(dec_a), 32'(fields[7*(i/2) +: 7]));
        if (c >= 2)
          chk($sformatf("%s val i%0d c%0d", name, i, c), 32'(digit_val), 32'(digits[4*i +: 4]));
        tick();
      end
    end
  endtask

  // Digit values, idx 11 in the leftmost nibble down to idx 0 on the right.
  localparam logic [47:0] D_37   = 48'h990914230537;
  localparam logic [47:0] D_38   = 48'h990914230538;
  localparam logic [47:0] D_Y120 = 48'hBB0914230538;
  localparam logic [41:0] F_37   = {7'd99, 7'd9, 7'd14, 7'd23, 7'd5, 7'd37};
  localparam logic [41:0] F_38   = {7'd99, 7'd9, 7'd14, 7'd23, 7'd5, 7'd38};
  localparam logic [41:0] F_Y120 = {7'd120, 7'd9, 7'd14, 7'd23, 7'd5, 7'd38};
  localparam logic [11:0] B_HOUR = 12'h030;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; enable = 1'b1; edit_sel = 3'd0;
    sec = 7'd37; min = 7'd5; hour = 7'd23; day = 7'd14; mon = 7'd9; year = 7'd99;
    repeat (3) @(posedge clk);
    #1;
    chk("rst digit_en", 32'(digit_en), 32'd0);
    chk("rst dec_a", 32'(dec_a), 32'd0);
    chk("rst digit_val", 32'(digit_val), 32'd0);
    chk("rst frame_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();  // IDLE -> ADDR of digit 0

    // Frame 0: basic scan sequence
    run_frame("f0", D_37, F_37, 12'd0, -1, 7'd0, 12);
    // Frame 1: sec changes mid-frame, the snapshot keeps 37
    run_frame("f1", D_37, F_37, 12'd0, 4, 7'd38, 12);
    // Frame 2: the new value appears
    run_frame("f2", D_38, F_38, 12'd0, -1, 7'd0, 12);

    // Frames 3..7: hour blinks whenever frame counter bit 1 is set
    edit_sel = 3'd3;
    run_frame("f3", D_38, F_38, B_HOUR, -1, 7'd0, 12);
    run_frame("f4", D_38, F_38, 12'd0,  -1, 7'd0, 12);
    run_frame("f5", D_38, F_38, 12'd0,  -1, 7'd0, 12);
    run_frame("f6", D_38, F_38, B_HOUR, -1, 7'd0, 12);
    run_frame("f7", D_38, F_38, B_HOUR, -1, 7'd0, 12);
    edit_sel = 3'd0;

    // Frame 8: year out of range shows the error glyph on digits 10/11
    year = 7'd120;
    run_frame("f8", D_Y120, F_Y120, 12'd0, -1, 7'd0, 12);
    year = 7'd99;

    // Frame 9: drop enable during SHOW of idx 6
    run_frame("f9", D_38, F_38, 12'd0, -1, 7'd0, 6);
    chk("en_drop pre digit_en", 32'(digit_en), 32'h040);
    enable = 1'b0;
    tick();
    chk("en_drop digit_en", 32'(digit_en), 32'd0);
    chk("en_drop dec_a", 32'(dec_a), 32'd0);
    chk("en_drop digit_val", 32'(digit_val), 32'd0);
    chk("en_drop frame_tick", 32'(frame_tick), 32'd0);
    tick();
    chk("idle digit_en", 32'(digit_en), 32'd0);
    enable = 1'b1;
    tick();  // IDLE -> ADDR of digit 0
    run_frame("reen", D_38, F_38, 12'd0, -1, 7'd0, 12);

    // Asynchronous reset in SHOW of idx 3, applied between clock edges
    run_frame("pre_rst", D_38, F_38, 12'd0, -1, 7'd0, 3);
    chk("pre_rst digit_en", 32'(digit_en), 32'h008);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst digit_en", 32'(digit_en), 32'd0);
    chk("async_rst digit_val", 32'(digit_val), 32'd0);
    chk("async_rst dec_a", 32'(dec_a), 32'd0);
    chk("async_rst frame_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_frame("post_rst", D_38, F_38, 12'd0, -1, 7'd0, 12);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog keeps the run bounded even if the sequence stalls.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed display scheduler for the century clock. Shares the single binary-to-BCD decoder (7-bit value in; unit and tens digits out) across six time fields: sec, min, hour, day, month, year-of-century. Drives a 12-digit multiplexed 7-segment bank one digit at a time. Supports blanking of the field under edit for set-mode blink. Sits between the timekeeping counters and the segment encoder/pad drivers.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; legal minimum 4.
BLINK_LOG2, 5, blink half-period = 2^BLINK_LOG2 frames.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan running; 0 = display off
sec  in  7  seconds field, binary
min  in  7  minutes field, binary
hour  in  7  hours field, binary
day  in  7  day field, binary
mon  in  7  month field, binary
year  in  7  year-of-century field, binary
edit_sel  in  3  0 = no edit; 1..6 = field under edit (1=sec … 6=year); 7 treated as 0
dec_a  out  7  value presented to the shared decoder
dec_unit  in  4  decoder units digit (combinational from dec_a)
dec_tens  in  4  decoder tens digit (combinational from dec_a)
digit_val  out  4  BCD value for the active digit
digit_en  out  12  one-hot digit enable, active high; bit 2f = units of field f, bit 2f+1 = tens of field f (f=0 sec … 5 year)
frame_tick  out  1  one-cycle pulse at the end of each 12-digit frame

Behaviour:
- Clocking and reset: all state is in the clk domain. Asynchronous reset (rst_n=0) forces: state IDLE, dec_a=0, digit_val=0, digit_en=0, frame_tick=0, slot counter=0, digit index=0, frame counter=0, snapshot registers=0.
- FSM states: IDLE, ADDR, LATCH, SHOW.
  - IDLE: all outputs held at their reset values. Leave IDLE for ADDR when enable=1, with digit index=0.
  - ADDR (1 cycle, slot count 0): register dec_a = snapshot of field (idx>>1); digit_en=0.
  - LATCH (1 cycle, slot count 1): register digit_val = dec_unit if idx is even, dec_tens if idx is odd; digit_en=0. These two cycles are the inter-digit dead time.
  - SHOW (slot counts 2..SCAN_DIV-1): digit_en = 1<<idx unless blanked; digit_val held.
  - On the last SHOW cycle, go to ADDR. idx increments, wrapping 11→0.
- Digit slot length: exactly SCAN_DIV cycles. Frame length: 12×SCAN_DIV cycles.
- Snapshot: on the ADDR cycle of idx 0, all six fields are captured into snapshot registers. The whole frame displays that one consistent sample, so there is no tearing across a rollover.
- frame_tick: asserted for the one cycle in which state moves from SHOW(idx 11) to ADDR(idx 0). The frame counter increments on that same edge and wraps freely.
- Blink:
  - blink_off = frame_counter bit BLINK_LOG2.
  - In SHOW, if edit_sel == f+1 (f = idx>>1) and blink_off=1, then digit_en=0 for that slot.
  - Timing, digit_val and the other fields are unaffected.
  - edit_sel is sampled every cycle; a change takes effect immediately within SHOW.
- Out-of-range fields (>99): the decoder returns 11; digit_val passes 4'd11 through unchanged. The downstream encoder treats it as an error glyph.
- enable deasserted in any state: next cycle the state is IDLE and outputs are at reset values. Slot counter, idx and frame counter clear. Re-enable restarts at idx 0 with a fresh snapshot.
- Reset mid-slot: immediate return to the reset state, no partial digit_en pulse.
- Guarantees:
  - digit_en is never multi-hot.
  - digit_en is always 0 in ADDR and LATCH.

Test Plan:
1. SCAN_DIV=4; enable=1; sec=37, min=5, hour=23, day=14, mon=9, year=99; edit_sel=0 → per slot: 2 dead cycles then 2 cycles of digit_en. Digit sequence 7,3,5,0,3,2,4,1,9,0,9,9 on digit_en bits 0..11. frame_tick every 48 cycles.
2. Change sec 37→38 during idx 4 of a frame → remainder of the frame still shows 7,3. Next frame shows 8,3.
3. SCAN_DIV=4, BLINK_LOG2=1, edit_sel=3 (hour) → digit_en bits 4,5 suppressed in frames 2,3,6,7,…. All other bits are present every frame.
4. Drop enable during SHOW of idx 6 → next cycle digit_en=0, dec_a=0, digit_val=0. Re-enable → first enabled digit is bit 0 after 2 dead cycles.
5. year=120 → digits 10 and 11 show digit_val=11. All other digits are normal.
6. Assert rst_n=0 asynchronously mid-SHOW → outputs go to 0 without waiting for a clk edge. After release with enable=1, the sequence restarts at idx 0.
